// File: rtl/led_pkg.sv
// Shared defaults and types for the LED comet-tail PWM driver.
package led_pkg;

  localparam int N_LEDS   = 4;
  localparam int PWM_BITS = 8;

  typedef logic [PWM_BITS-1:0] bright_t;

  localparam bright_t BRIGHT_MAX = '1;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness with saturating decay, frame-boundary duty shadow,
// PWM compare and registered pin drive.
module led_pwm_channel #(
  parameter int PWM_BITS   = led_pkg::PWM_BITS,
  parameter int DECAY_STEP = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                pattern_bit,
  input  logic                decay_tick,
  input  logic                frame_end,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] FULL_SCALE = '1;
  localparam logic [PWM_BITS:0]   STEP       = (PWM_BITS+1)'(DECAY_STEP);

  logic [PWM_BITS-1:0] bright_reg;
  logic [PWM_BITS-1:0] bright_next;
  logic [PWM_BITS-1:0] duty_reg;
  logic [PWM_BITS:0]   decay_diff;

  // One extra bit so a borrow clamps to zero instead of wrapping to a bright value.
  assign decay_diff = {1'b0, bright_reg} - STEP;

  always_comb begin
    bright_next = bright_reg;
    if (!enable) begin
      bright_next = '0;
    end else if (pattern_bit) begin
      bright_next = FULL_SCALE;
    end else if (decay_tick) begin
      bright_next = decay_diff[PWM_BITS] ? '0 : decay_diff[PWM_BITS-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bright_reg <= '0;
      duty_reg   <= '0;
      led        <= 1'b0;
    end else begin
      bright_reg <= bright_next;
      if (frame_end) begin
        duty_reg <= bright_reg;
      end
      led <= enable & (pwm_cnt < duty_reg);
    end
  end

endmodule

// File: rtl/led_trail_pwm.sv
// Comet-tail LED driver: turns the rotator's one-hot pattern into per-LED PWM that
// lights fully on request and then fades out in fixed steps.
module led_trail_pwm #(
  parameter int N_LEDS     = led_pkg::N_LEDS,
  parameter int PWM_BITS   = led_pkg::PWM_BITS,
  parameter int DECAY_DIV  = 120000,
  parameter int DECAY_STEP = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [N_LEDS-1:0] pattern_in,
  output logic [N_LEDS-1:0] led_out,
  output logic              frame_start
);

  localparam int                PRE_W    = $clog2(DECAY_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(DECAY_DIV - 1);
  localparam logic [PWM_BITS-1:0] CNT_LAST = '1;

  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic [PRE_W-1:0]    prescaler_reg;
  logic [N_LEDS-1:0]   pattern_q_reg;
  logic                decay_tick;
  logic                frame_end;

  assign decay_tick = (prescaler_reg == PRE_LAST);
  assign frame_end  = (pwm_cnt_reg == CNT_LAST);

  // Prescaler keeps running while disabled so fade timing stays on a fixed grid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_reg   <= '0;
      prescaler_reg <= '0;
      pattern_q_reg <= '0;
      frame_start   <= 1'b0;
    end else begin
      pwm_cnt_reg   <= pwm_cnt_reg + 1'b1;
      prescaler_reg <= decay_tick ? '0 : prescaler_reg + 1'b1;
      pattern_q_reg <= pattern_in;
      frame_start   <= (pwm_cnt_reg == '0);
    end
  end

  generate
    for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_chan
      led_pwm_channel #(
        .PWM_BITS   (PWM_BITS),
        .DECAY_STEP (DECAY_STEP)
      ) u_chan (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pattern_bit (pattern_q_reg[gi]),
        .decay_tick  (decay_tick),
        .frame_end   (frame_end),
        .pwm_cnt     (pwm_cnt_reg),
        .led         (led_out[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_led_trail_pwm.sv
// Directed bench for led_trail_pwm with a cycle-level reference model and
// hand-computed per-frame on-count expectations.
module tb_led_trail_pwm;

  localparam int NL    = 4;
  localparam int PB    = 4;
  localparam int DIV   = 4;
  localparam int STEP  = 5;
  localparam int FRAME = 16;
  localparam int FULL  = 15;
  localparam int NFR   = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [NL-1:0] pattern_in = '0;
  logic [NL-1:0] led_out;
  logic          frame_start;

  led_trail_pwm #(
    .N_LEDS     (NL),
    .PWM_BITS   (PB),
    .DECAY_DIV  (DIV),
    .DECAY_STEP (STEP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .pattern_in  (pattern_in),
    .led_out     (led_out),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: k counts clock edges since reset; PWM phase and decay ticks
  // follow from k by modular arithmetic.
  int            k = 0;
  int            bright_m [NL];
  int            duty_m   [NL];
  logic [NL-1:0] req_m   = '0;
  logic [NL-1:0] exp_led = '0;
  logic          exp_fs  = 1'b0;

  initial begin
    for (int c = 0; c < NL; c++) begin
      bright_m[c] = 0;
      duty_m[c]   = 0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        k = 0;
        req_m = '0;
        exp_led = '0;
        exp_fs = 1'b0;
        for (int c = 0; c < NL; c++) begin
          bright_m[c] = 0;
          duty_m[c]   = 0;
        end
      end else begin
        exp_fs = ((k % FRAME) == 0);
        for (int c = 0; c < NL; c++)
          exp_led[c] = enable && ((k % FRAME) < duty_m[c]);
        if ((k % FRAME) == FRAME - 1)
          for (int c = 0; c < NL; c++) duty_m[c] = bright_m[c];
        for (int c = 0; c < NL; c++) begin
          if (!enable)       bright_m[c] = 0;
          else if (req_m[c]) bright_m[c] = FULL;
          else if ((k % DIV) == DIV - 1)
            bright_m[c] = (bright_m[c] > STEP) ? bright_m[c] - STEP : 0;
        end
        req_m = pattern_in;
        k++;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check($sformatf("led_out k=%0d", k), int'(led_out), int'(exp_led));
      check($sformatf("frame_start k=%0d", k), int'(frame_start), int'(exp_fs));
    end
  end

  // Per-frame on-count log, framed by the DUT's own frame_start pulses.
  int fcnt [0:31][0:NL-1];
  int acc  [NL];
  int cur_f = -1;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        cur_f = -1;
        for (int f = 0; f < 32; f++)
          for (int c = 0; c < NL; c++) fcnt[f][c] = -1;
        for (int c = 0; c < NL; c++) acc[c] = 0;
      end else if (frame_start) begin
        if (cur_f >= 0 && cur_f < 32)
          for (int c = 0; c < NL; c++) fcnt[cur_f][c] = acc[c];
        cur_f = (k - 1) / FRAME;
        for (int c = 0; c < NL; c++) acc[c] = int'(led_out[c]);
      end else begin
        for (int c = 0; c < NL; c++) acc[c] += int'(led_out[c]);
      end
    end
  end

  task automatic at_k(input int target);
    int n;
    n = 0;
    while (k != target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (k != target) begin
      total++;
      bad++;
      $display("FAIL timeline: reached k=%0d, expected k=%0d", k, target);
    end
  endtask

  int exp_tab [0:NFR-1][0:NL-1];

  initial begin
    exp_tab = '{
      '{0, 0, 0, 0},    // 0
      '{15, 0, 0, 0},   // 1  full after one-cycle request
      '{0, 0, 0, 0},    // 2  decayed to 0, no wrap
      '{10, 0, 0, 0},   // 3  one tick before shadow load
      '{0, 0, 0, 0},    // 4
      '{5, 0, 0, 0},    // 5  two ticks before shadow load
      '{0, 0, 0, 0},    // 6
      '{0, 15, 0, 0},   // 7  held request beats ticks
      '{0, 15, 0, 0},   // 8
      '{0, 15, 0, 0},   // 9
      '{0, 0, 0, 0},    // 10
      '{5, 15, 0, 0},   // 11 rotation: trailing LED dimmer
      '{0, 0, 5, 15},   // 12
      '{0, 0, 0, 0},    // 13 mid-frame request does not show yet
      '{0, 0, 10, 0},   // 14 shows from next frame
      '{4, 4, 4, 4},    // 15 enable dropped after 4 cycles
      '{0, 0, 0, 0},    // 16
      '{0, 0, 0, 0}     // 17 re-enabled with no request: dark
    };

    repeat (2) @(negedge clk);
    check("reset led_out", int'(led_out), 0);
    check("reset frame_start", int'(frame_start), 0);

    // Light everything, then reset asynchronously in the middle of a lit cycle.
    rst = 1'b0;
    enable = 1'b1;
    pattern_in = 4'b1111;
    at_k(4);  pattern_in = 4'b0000;
    at_k(17);
    check("pre-reset led_out", int'(led_out), 15);
    check("pre-reset frame_start", int'(frame_start), 1);
    #2 rst = 1'b1;
    #1;
    check("async reset led_out", int'(led_out), 0);
    check("async reset frame_start", int'(frame_start), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    at_k(13);  pattern_in = 4'b0001;
    at_k(14);  pattern_in = 4'b0000;
    at_k(41);  pattern_in = 4'b0001;
    at_k(42);  pattern_in = 4'b0000;
    at_k(69);  pattern_in = 4'b0001;
    at_k(70);  pattern_in = 4'b0000;
    at_k(96);  pattern_in = 4'b0010;
    at_k(141); pattern_in = 4'b0000;
    at_k(158); pattern_in = 4'b0001;
    at_k(166); pattern_in = 4'b0010;
    at_k(174); pattern_in = 4'b0100;
    at_k(182); pattern_in = 4'b1000;
    at_k(190); pattern_in = 4'b0000;
    at_k(212); pattern_in = 4'b0100;
    at_k(216); pattern_in = 4'b0000;
    at_k(232); pattern_in = 4'b1111;
    at_k(236); pattern_in = 4'b0000;
    at_k(244); enable = 1'b0;
    at_k(260); enable = 1'b1;
    at_k(300);

    for (int f = 0; f < NFR; f++)
      for (int c = 0; c < NL; c++)
        check($sformatf("frame %0d ch%0d on-count", f, c), fcnt[f][c], exp_tab[f][c]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
